// File: rtl/pergate_addmul_pkg.sv
// Shared FSM state, mode encodings and flattened-vector helpers for the per-gate add/mul sequencer.
// Field width follows the global `F_NBITS define (defaults to 32 when not supplied by the build).
`ifndef F_NBITS
`define F_NBITS 32
`endif

package pergate_addmul_pkg;

    localparam int FW = `F_NBITS;

    // Field modulus p = 2^32 - 5, truncated to the field width.
    localparam logic [63:0]   P_MOD_64 = 64'd4294967291;
    localparam logic [FW-1:0] P_MOD    = P_MOD_64[FW-1:0];

    // Flattened word vectors are zero-extended to this width before slicing.
    localparam int WS_MAXW = 64 * FW;

    localparam logic MODE_INIT   = 1'b0;
    localparam logic MODE_UPDATE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic [FW-1:0] word_slice(input logic [WS_MAXW-1:0] vec, input int idx);
        return vec[idx*FW +: FW];
    endfunction

endpackage

// File: rtl/addmul_lane.sv
// One accumulator lane: operand muxes, a field multiplier, the accumulator and its step-done flag.
// i_a_prev is the prior accumulator value; i_force_one replaces it with 1 on the first INIT step.
module addmul_lane
    import pergate_addmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_force_one,
    input  logic [FW-1:0] i_a_prev,
    input  logic          i_sel,
    input  logic [FW-1:0] i_tau,
    input  logic [FW-1:0] i_mtau,
    input  logic          i_clr,
    output logic [FW-1:0] o_acc,
    output logic          o_done
);

    logic [FW-1:0] w_a;
    logic [FW-1:0] w_b;
    logic [FW-1:0] w_prod;
    logic          w_rdy;
    logic [FW-1:0] r_acc;
    logic          r_done;

    assign w_a = i_force_one ? {{(FW-1){1'b0}}, 1'b1} : i_a_prev;
    assign w_b = i_sel ? i_tau : i_mtau;

    field_multiplier u_mul (
        .clk           (clk),
        .rst           (rst),
        .i_en          (i_en),
        .i_a           (w_a),
        .i_b           (w_b),
        .o_ready_pulse (w_rdy),
        .o_prod        (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_rdy) begin
                r_acc <= w_prod;
            end
            if (i_clr) begin
                r_done <= 1'b0;
            end else if (w_rdy) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_done = r_done;

endmodule

// File: rtl/field_multiplier.sv
// Two-stage modular multiplier: raw product, then reduction mod p.
// o_ready_pulse is high for one cycle, two cycles after i_en was sampled.
module field_multiplier
    import pergate_addmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [FW-1:0] i_a,
    input  logic [FW-1:0] i_b,
    output logic          o_ready_pulse,
    output logic [FW-1:0] o_prod
);

    logic [2*FW-1:0] r_prod_p0;
    logic            r_vld_p0;
    logic [FW-1:0]   r_res_p1;
    logic            r_vld_p1;

    function automatic logic [FW-1:0] mod_reduce(input logic [2*FW-1:0] x);
        logic [2*FW-1:0] w_q;
        w_q = x % {{FW{1'b0}}, P_MOD};
        return w_q[FW-1:0];
    endfunction

    // p0: full-width product of the reduced operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= i_en;
        end
        if (i_en) begin
            r_prod_p0 <= (2*FW)'(i_a) * (2*FW)'(i_b);
        end
    end

    // p1: reduction mod p
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0;
        end
        if (r_vld_p0) begin
            r_res_p1 <= mod_reduce(r_prod_p0);
        end
    end

    assign o_ready_pulse = r_vld_p1;
    assign o_prod        = r_res_p1;

endmodule

// File: rtl/pergate_addmul_seq.sv
// Per-gate add/mul wiring-predicate sequencer: INIT folds all tau words per gate label, UPDATE folds one challenge.
// Define PERGATE_ADDMUL_SHARED_MUL_EN to time-share a single lane multiplier round-robin across channels.
module pergate_addmul_seq
    import pergate_addmul_pkg::*;
#(
    parameter int NBITS_GATE = 8,
    parameter int NCHAN      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    input  logic [NCHAN*NBITS_GATE-1:0]     gate_ids,
    input  logic [NCHAN-1:0]                upd_bits,
    input  logic [NBITS_GATE*`F_NBITS-1:0]  tau_vec,
    input  logic [NBITS_GATE*`F_NBITS-1:0]  m_tau_vec,
    output logic                            busy,
    output logic                            done_pulse,
    output logic [NCHAN*`F_NBITS-1:0]       addmul
);

    localparam int KW = (NBITS_GATE > 1) ? $clog2(NBITS_GATE) : 1;

    state_t                        r_state;
    logic [KW-1:0]                 r_k;
    logic [NCHAN*NBITS_GATE-1:0]   r_gate_ids;
    logic [NCHAN-1:0]              r_upd_bits;
    logic                          r_mode;
    logic                          r_busy;
    logic                          r_done_pulse;

    logic                          w_issue;
    logic                          w_first;
    logic                          w_last;
    logic [NCHAN-1:0]              w_sel;
    logic [FW-1:0]                 w_tau;
    logic [FW-1:0]                 w_mtau;
    logic                          w_step_done;
    logic                          w_lane_done;

    assign w_issue = (r_state == S_ISSUE);
    assign w_first = (r_mode == MODE_INIT) && (r_k == '0);
    assign w_last  = (r_mode == MODE_UPDATE) || (int'(r_k) == NBITS_GATE - 1);

    // UPDATE always runs with k held at 0, so word k doubles as the r / 1-r word.
    assign w_tau  = word_slice(WS_MAXW'(tau_vec), int'(r_k));
    assign w_mtau = word_slice(WS_MAXW'(m_tau_vec), int'(r_k));

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < NCHAN; c++) begin
            w_sel[c] = (r_mode == MODE_INIT) ? r_gate_ids[c*NBITS_GATE + int'(r_k)] : r_upd_bits[c];
        end
    end

`ifdef PERGATE_ADDMUL_SHARED_MUL_EN
    localparam int LW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [LW-1:0]  r_lane;
    logic [FW-1:0]  r_acc [NCHAN];
    logic [FW-1:0]  w_lane_acc;
    logic           w_lane_flag;

    assign w_lane_done = (r_state == S_WAIT) && w_lane_flag;
    assign w_step_done = w_lane_done && (int'(r_lane) == NCHAN - 1);

    addmul_lane u_lane (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_issue),
        .i_force_one (w_first),
        .i_a_prev    (r_acc[r_lane]),
        .i_sel       (w_sel[r_lane]),
        .i_tau       (w_tau),
        .i_mtau      (w_mtau),
        .i_clr       (w_lane_done),
        .o_acc       (w_lane_acc),
        .o_done      (w_lane_flag)
    );

    // The shared lane's result is parked in the serviced channel's accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_lane_done) begin
            r_acc[r_lane] <= w_lane_acc;
            r_lane        <= w_step_done ? '0 : r_lane + LW'(1);
        end
    end

    always_comb begin
        addmul = '0;
        for (int c = 0; c < NCHAN; c++) begin
            addmul[c*FW +: FW] = r_acc[c];
        end
    end
`else
    logic [FW-1:0]    w_acc [NCHAN];
    logic [NCHAN-1:0] w_done;

    assign w_step_done = (r_state == S_WAIT) && (&w_done);
    assign w_lane_done = w_step_done;

    for (genvar c = 0; c < NCHAN; c++) begin : g_lane
        addmul_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_en        (w_issue),
            .i_force_one (w_first),
            .i_a_prev    (w_acc[c]),
            .i_sel       (w_sel[c]),
            .i_tau       (w_tau),
            .i_mtau      (w_mtau),
            .i_clr       (w_step_done),
            .o_acc       (w_acc[c]),
            .o_done      (w_done[c])
        );
        assign addmul[c*FW +: FW] = w_acc[c];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_mode       <= MODE_INIT;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gate_ids <= gate_ids;
                        r_upd_bits <= upd_bits;
                        r_mode     <= mode;
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_step_done) begin
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_done_pulse <= 1'b1;
                        end else begin
                            r_k     <= r_k + KW'(1);
                            r_state <= S_ISSUE;
                        end
                    end else if (w_lane_done) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_pergate_addmul_seq.sv
// Scoreboard bench for pergate_addmul_seq with NBITS_GATE=3, NCHAN=2 and p = 2^32-5.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_pergate_addmul_seq;

    localparam int NB   = 3;
    localparam int NCH  = 2;
    localparam int TB_L = 2;
`ifdef PERGATE_ADDMUL_SHARED_MUL_EN
    localparam int STEP = NCH * (TB_L + 2);
`else
    localparam int STEP = TB_L + 2;
`endif
    localparam int LAT_INIT = NB * STEP + 1;
    localparam int LAT_UPD  = STEP + 1;
    localparam logic [31:0] P = 32'd4294967291;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [NCH*NB-1:0]      gate_ids;
    logic [NCH-1:0]         upd_bits;
    logic [NB*32-1:0]       tau_vec;
    logic [NB*32-1:0]       m_tau_vec;
    logic                   busy;
    logic                   done_pulse;
    logic [NCH*32-1:0]      addmul;

    pergate_addmul_seq #(.NBITS_GATE(NB), .NCHAN(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .gate_ids   (gate_ids),
        .upd_bits   (upd_bits),
        .tau_vec    (tau_vec),
        .m_tau_vec  (m_tau_vec),
        .busy       (busy),
        .done_pulse (done_pulse),
        .addmul     (addmul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        int          c0;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done_pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done_pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_ch0"}, addmul[31:0], e.e0);
                chk({e.name, "_ch1"}, addmul[63:32], e.e1);
                chk({e.name, "_latency"}, 32'(cyc - e.c0), 32'(e.lat));
                chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic set_tau_init();
        tau_vec   = {32'd5, 32'd3, 32'd2};
        m_tau_vec = {P - 32'd4, P - 32'd2, P - 32'd1};
    endtask

    task automatic set_tau_upd();
        tau_vec   = {32'd5, 32'd3, 32'd7};
        m_tau_vec = {P - 32'd4, P - 32'd2, P - 32'd6};
    endtask

    task automatic issue(input logic m, input logic [NCH*NB-1:0] gids, input logic [NCH-1:0] ub,
                         input bit push, input logic [31:0] e0, input logic [31:0] e1,
                         input int lat, input string nm);
        exp_t e;
        @(negedge clk);
        mode     = m;
        gate_ids = gids;
        upd_bits = ub;
        start    = 1'b1;
        if (push) begin
            e.e0   = e0;
            e.e1   = e1;
            e.c0   = cyc;
            e.lat  = lat;
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done_pulse !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no done_pulse in %0d cycles expected one", nm, n);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        gate_ids = '0;
        upd_bits = '0;
        set_tau_init();
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done_pulse}, 32'd0);
        chk("reset_addmul", addmul[31:0] | addmul[63:32], 32'd0);
        rst = 1'b0;

        // UPDATE straight out of reset multiplies a zero accumulator
        set_tau_upd();
        issue(1'b1, '0, 2'b11, 1'b1, 32'd0, 32'd0, LAT_UPD, "upd_zero");
        wait_done("upd_zero");

        set_tau_init();
        issue(1'b0, {3'b000, 3'b101}, 2'b00, 1'b1, P - 32'd20, P - 32'd8, LAT_INIT, "initA");
        wait_done("initA");

        set_tau_upd();
        issue(1'b1, '0, 2'b01, 1'b1, P - 32'd140, 32'd48, LAT_UPD, "updA");
        wait_done("updA");

        // A second start while busy must be dropped
        set_tau_init();
        issue(1'b0, {3'b010, 3'b111}, 2'b00, 1'b1, 32'd30, 32'd12, LAT_INIT, "initB");
        repeat (3) @(negedge clk);
        gate_ids = '0;
        mode     = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("initB");

        // Abort in the cycle the first-step products become ready
        issue(1'b0, {3'b000, 3'b101}, 2'b00, 1'b0, 32'd0, 32'd0, 0, "abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ch0", addmul[31:0], 32'd0);
        chk("abort_ch1", addmul[63:32], 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        issue(1'b0, {3'b000, 3'b101}, 2'b00, 1'b1, P - 32'd20, P - 32'd8, LAT_INIT, "initC");
        wait_done("initC");

        // Back-to-back: start in the cycle right after done_pulse
        set_tau_upd();
        issue(1'b1, '0, 2'b01, 1'b1, P - 32'd140, 32'd48, LAT_UPD, "updB2B");
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("updB2B");

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
